// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry. Fetch asks for a prediction. The prediction is registered and
// appears one cycle later. The branch unit reports resolved branches to
// train the table.
//
// Interface semantics:
//   lookup_valid_i is a one-cycle request qualifier. No backpressure exists,
//   and every request produces exactly one registered response with
//   pred_valid_o high in the following cycle. The branch unit pushes
//   update_i as a fire-and-forget strobe. flush_i is also a strobe.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   lookup_valid_i      request a prediction for lookup_pc_i this cycle
//   lookup_pc_i         fetch PC to predict
//   update_i            resolved-branch strobe
//   update_pc_i         PC of the resolved branch
//   update_taken_i      resolved direction
//   update_target_i     resolved target
//   flush_i             invalidate whole table at next edge
//   pred_valid_o        prediction outputs belong to last cycle's request
//   pred_taken_o        predicted taken
//   pred_target_o       predicted next PC
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lookup_valid_i,
    input  logic [31:0] lookup_pc_i,
    input  logic        update_i,
    input  logic [31:0] update_pc_i,
    input  logic        update_taken_i,
    input  logic [31:0] update_target_i,
    input  logic        flush_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = 30 - IW;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;
    localparam logic [1:0] CTR_SNT = 2'b00;

    // Table storage.
    logic [ENTRIES-1:0]         valid_q, valid_d;
    logic [ENTRIES-1:0][TW-1:0] tag_q,   tag_d;
    logic [ENTRIES-1:0][31:0]   target_q, target_d;
    logic [ENTRIES-1:0][1:0]    ctr_q,   ctr_d;

    // Registered prediction.
    logic        pred_valid_q,  pred_valid_d;
    logic        pred_taken_q,  pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;

    // Address split.
    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic [IW-1:0] up_idx;
    logic [TW-1:0] up_tag;
    logic          lk_hit;
    logic          up_hit;

    // Byte-offset bits of the update PC play no role in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^update_pc_i[1:0];

    assign lk_idx = lookup_pc_i[IW+1:2];
    assign lk_tag = lookup_pc_i[31:IW+2];
    assign up_idx = update_pc_i[IW+1:2];
    assign up_tag = update_pc_i[31:IW+2];

    // The lookup reads the current table state. Therefore a same-cycle
    // update or flush only affects the following lookups.
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Prediction path.
    always_comb begin
        pred_valid_d  = lookup_valid_i;
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (lookup_valid_i) begin
            if (lk_hit && ctr_q[lk_idx][1]) begin
                pred_taken_d  = 1'b1;
                pred_target_d = target_q[lk_idx];
            end else begin
                pred_taken_d  = 1'b0;
                pred_target_d = lookup_pc_i + 32'd4;
            end
        end
    end

    // Table update path; flush takes priority over training.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_i) begin
            valid_d = '0;
            ctr_d   = {ENTRIES{CTR_WNT}};
        end else if (update_i) begin
            if (up_hit) begin
                if (update_taken_i) begin
                    if (ctr_q[up_idx] != CTR_ST) begin
                        ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                    end
                    target_d[up_idx] = update_target_i;
                end else begin
                    if (ctr_q[up_idx] != CTR_SNT) begin
                        ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                    end
                end
            end else if (update_taken_i) begin
                // Allocation evicts whatever occupies the slot.
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = update_target_i;
                ctr_d[up_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q       <= '0;
            tag_q         <= '0;
            target_q      <= '0;
            ctr_q         <= {ENTRIES{CTR_WNT}};
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
            pred_valid_q  <= pred_valid_d;
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_valid_o  = pred_valid_q;
    assign pred_taken_o  = pred_taken_q;
    assign pred_target_o = pred_target_q;

endmodule
